uart_mem_dump: RTL and testbench
================================

// Module: uart_mem_dump
// PURPOSE
// - RIB bus master that reads a block of words from memory and sends them out on a UART TX pin.
// - It is the upload counterpart of the UART download path: the host reads back ROM/RAM contents for verification.
// - Sits on a spare RIB master port (m2) beside the UART download master; drives its own TX pin.
// PARAMETERS
// - BAUD_DIV  434  clk cycles per UART bit (50 MHz / 115200); must be >= 2
// - SYNC_BYTE 8'hA5  header byte sent before data
// PORTS
// - clk          in   1   system clock
// - rst          in   1   reset, synchronous, active-high
// - start_i      in   1   1-cycle pulse: begin dump; ignored while busy_o=1
// - base_addr_i  in   32  first word address, sampled at start; bits[1:0] forced to 0
// - word_cnt_i   in   16  number of 32-bit words, sampled at start; 0 is legal
// - req_o        out  1   RIB request
// - we_o         out  1   RIB write enable, constant 0
// - addr_o       out  32  RIB address
// - wdata_o      out  32  RIB write data, constant 0
// - rdata_i      in   32  RIB read data
// - tx_o         out  1   UART TX line, 8N1, idle high
// - busy_o       out  1   high from the cycle after an accepted start through the last stop bit
// - done_o       out  1   1-cycle pulse after the checksum stop bit completes
// BEHAVIOUR
// - Reset values: req_o=0, addr_o=0, tx_o=1, busy_o=0, done_o=0. Reset mid-frame aborts: tx_o goes high in the next cycle with no partial-byte completion.
// - Frame format: SYNC_BYTE; then each word LSB byte first; then CKSUM = 8-bit sum mod 256 of all data bytes. The header is excluded from CKSUM.
// - FSM states:
//   - IDLE: start_i=1 latches addr, cnt, cksum=0 -> HDR.
//   - HDR: send SYNC_BYTE, wait for byte done -> cnt==0 ? CKS : RD_REQ.
//   - RD_REQ: req_o=1 with addr_o=addr for exactly 1 cycle -> RD_CAP.
//   - RD_CAP: req_o stays 1; rdata_i is captured into a word register this cycle; addr+=4 (wraps 0xFFFFFFFC->0); cnt-=1 -> SEND.
//   - SEND: send bytes [7:0],[15:8],[23:16],[31:24] and add each to cksum. After the 4th byte: cnt==0 ? CKS : RD_REQ.
//   - CKS: send cksum -> DONE.
//   - DONE: done_o=1 for 1 cycle -> IDLE.
// - req_o is high only in RD_REQ and RD_CAP, never while a byte is shifting. The bus read therefore never overlaps TX timing.
// - Byte TX: start bit 0, d0..d7, stop bit 1, each BAUD_DIV cycles; byte period = 10*BAUD_DIV.
//   - Next byte start bit begins at most 1 cycle after the previous stop bit ends.
//   - The gap between data words is bounded by 3 cycles (RD_REQ, RD_CAP, load).
// - start_i during busy_o=1 or DONE: ignored, with no effect on the latched params.
// - start_i in the same cycle as rst: reset wins.
// - Total frame bytes = 2 + 4*word_cnt.
// STRUCTURE
// - Shared package/defines: RIB bus widths (MemAddrBus, MemBus), RstEnable, WriteDisable, ZeroWord.
// - Sub-module uart_tx_byte (clk, rst, data_i[7:0], valid_i, ready_o, tx_o):
//   - baud counter, 4-bit bit index, 10-bit shift register;
//   - ready_o=1 in idle; valid_i && ready_o accepts the byte.
// - Top level holds the FSM, addr/cnt/word/byte-index/cksum registers, and the RIB drive.
// TESTING (BAUD_DIV=4, bench RIB slave model returns mem[addr] combinationally, UART monitor decodes tx_o)
// - word_cnt=1, base=0x1000_0000, mem=0x44332211:
//   - bytes A5 11 22 33 44 AA;
//   - exactly one req_o read, at 0x1000_0000;
//   - done_o pulses once; busy_o low after it.
// - word_cnt=0 -> bytes A5 00, no req_o assertion, done_o pulse.
// - word_cnt=2, base=0x0000_0003, mem[0]=0xFFFFFFFF, mem[4]=0x00000001:
//   - reads at 0x0 then 0x4;
//   - bytes A5 FF FF FF FF 01 00 00 00 FD (sum wraps).
// - base=0xFFFF_FFFC, word_cnt=2: second read at 0x0000_0000.
// - start_i re-pulsed mid-frame with a different base/cnt: frame is unchanged, no second frame follows.
// - rst asserted during the 3rd data byte: next cycle tx_o=1, req_o=0, busy_o=0.
//   - A new start after release yields a clean full frame.
// - Bit timing: every bit of every byte lasts exactly 4 cycles; stop bit is 1; idle between frames is 1.

Source files
------------

// File: rtl/uart_mem_dump_pkg.sv
// Shared RIB bus constants and the memory-dump FSM state encoding.
package uart_mem_dump_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  localparam logic              RstEnable    = 1'b1;
  localparam logic              WriteDisable = 1'b0;
  localparam logic [MemBus-1:0] ZeroWord     = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_REQ,
    S_RD_CAP,
    S_SEND,
    S_CKS,
    S_DONE
  } dump_state_e;

endpackage

// File: rtl/uart_mem_dump_tx.sv
// 8N1 byte serialiser: start bit, d0..d7, stop bit, each BAUD_DIV clocks.
// ready_o also rises in the final stop-bit cycle so bytes can be chained back to back.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          bit_end;
  logic          last_cycle;

  assign bit_end    = (baud_q == CW'(BAUD_DIV - 1));
  assign last_cycle = busy_q && bit_end && (bit_q == 4'd9);
  assign ready_o    = !busy_q || last_cycle;
  // Shifting in ones leaves the register all-ones after the stop bit, so idle is high.
  assign tx_o       = shift_q[0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    if (busy_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
    if (valid_i && ready_o) begin
      shift_d = {1'b1, data_i, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/uart_mem_dump.sv
// RIB read master that streams a block of memory words out of a UART as
// SYNC_BYTE, data bytes (LSB first), then an 8-bit additive checksum.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int         BAUD_DIV  = 434,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [MemAddrBus-1:0] base_addr_i,
  input  logic [15:0]           word_cnt_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [MemAddrBus-1:0] addr_o,
  output logic [MemBus-1:0]     wdata_o,
  input  logic [MemBus-1:0]     rdata_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  dump_state_e           state_q, state_d;
  logic [MemAddrBus-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [MemBus-1:0]     word_q, word_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            cksum_q, cksum_d;

  logic       tx_valid, tx_ready;
  logic [7:0] tx_data, byte_sel;

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .data_i  (tx_data),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (tx_o)
  );

  assign we_o    = WriteDisable;
  assign wdata_o = ZeroWord;
  assign addr_o  = addr_q;
  assign busy_o  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o  = (state_q == S_DONE);

  always_comb begin
    case (idx_q[1:0])
      2'd0:    byte_sel = word_q[7:0];
      2'd1:    byte_sel = word_q[15:8];
      2'd2:    byte_sel = word_q[23:16];
      default: byte_sel = word_q[31:24];
    endcase
  end

  // idx_q counts bytes handed to the serialiser in the current state; once all are
  // handed over, the next tx_ready means the final stop bit is ending.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    idx_d    = idx_q;
    cksum_d  = cksum_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    req_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~32'h3;
          cnt_d   = word_cnt_i;
          cksum_d = 8'h00;
          idx_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_data = SYNC_BYTE;
        if (idx_q == 3'd0) begin
          tx_valid = 1'b1;
          if (tx_ready) idx_d = 3'd1;
        end else if (tx_ready) begin
          idx_d   = '0;
          state_d = (cnt_q == 16'd0) ? S_CKS : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        req_o   = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        req_o   = 1'b1;
        word_d  = rdata_i;
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q - 16'd1;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_data = byte_sel;
        if (idx_q != 3'd4) begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            cksum_d = cksum_q + byte_sel;
            idx_d   = idx_q + 3'd1;
          end
        end else if (tx_ready) begin
          idx_d   = '0;
          state_d = (cnt_q == 16'd0) ? S_CKS : S_RD_REQ;
        end
      end
      S_CKS: begin
        tx_data = cksum_q;
        if (idx_q == 3'd0) begin
          tx_valid = 1'b1;
          if (tx_ready) idx_d = 3'd1;
        end else if (tx_ready) begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      cksum_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Scoreboard bench for uart_mem_dump: expected UART bytes and RIB read addresses are
// queued by the stimulus; independent monitors decode tx_o / req_o and compare.
module tb_uart_mem_dump;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] word_cnt_i;
  logic        req_o, we_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic        tx_o, busy_o, done_o;

  always #5 clk = ~clk;

  uart_mem_dump #(.BAUD_DIV(BAUD), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .req_o       (req_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rdata_i     (rdata_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Small combinational RIB slave: four fixed addresses, data set per test.
  logic [31:0] mem_addr [4];
  logic [31:0] mem_data [4];

  always_comb begin
    rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++)
      if (addr_o == mem_addr[i]) rdata_i = mem_data[i];
  end

  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_reads [$];
  int pass_cnt    = 0;
  int chk_cnt     = 0;
  int byte_cnt    = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;
  logic mon_abort = 1'b0;
  logic req_prev  = 1'b0;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic push8(input logic [7:0] b);
    exp_bytes.push_back(b);
  endtask

  // RIB monitor: one read per rising edge of req_o.
  always @(negedge clk) begin
    if (req_o && !req_prev) begin
      if (exp_reads.size() == 0) begin
        check("rib_read_unexpected", 1'b0, addr_o, 32'h0);
      end else begin
        logic [31:0] e;
        e = exp_reads.pop_front();
        check("rib_read_addr", addr_o == e, addr_o, e);
        check("rib_we_wdata", (we_o == 1'b0) && (wdata_o == 32'h0), {31'h0, we_o} | wdata_o, 32'h0);
      end
    end
    if (req_o && tx_o == 1'b0) overlap_cnt++;
    if (done_o) done_cnt++;
    req_prev = req_o;
  end

  task automatic mon_sample(output logic v);
    @(negedge clk);
    v = tx_o;
    if (rst) mon_abort = 1'b1;
  endtask

  // UART monitor: each bit must hold its level for exactly BAUD samples.
  initial begin : uart_mon
    logic [7:0] got;
    logic       v, v0, ok;
    forever begin
      @(negedge clk);
      if (!rst && tx_o == 1'b0) begin
        mon_abort = 1'b0;
        ok = 1'b1;
        got = 8'h00;
        for (int c = 1; c < BAUD; c++) begin mon_sample(v); if (v !== 1'b0) ok = 1'b0; end
        for (int b = 0; b < 8; b++) begin
          mon_sample(v0);
          for (int c = 1; c < BAUD; c++) begin mon_sample(v); if (v !== v0) ok = 1'b0; end
          got[b] = v0;
        end
        for (int c = 0; c < BAUD; c++) begin mon_sample(v); if (v !== 1'b1) ok = 1'b0; end
        if (!mon_abort) begin
          byte_cnt++;
          check("uart_bit_timing", ok, {31'h0, ok}, 32'h1);
          if (exp_bytes.size() == 0) begin
            check("uart_byte_unexpected", 1'b0, {24'h0, got}, 32'h0);
          end else begin
            logic [7:0] e;
            e = exp_bytes.pop_front();
            check("uart_byte", got == e, {24'h0, got}, {24'h0, e});
          end
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [15:0] cnt);
    @(negedge clk);
    base_addr_i = base;
    word_cnt_i  = cnt;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o == 1'b1, {31'h0, busy_o}, 32'h1);
  endtask

  task automatic finish_frame(input int nbytes, input int d0);
    int limit;
    limit = nbytes * BAUD * 10 + 100;
    for (int i = 0; i < limit; i++) begin
      if (done_o) break;
      @(negedge clk);
    end
    check("done_seen", done_o == 1'b1, {31'h0, done_o}, 32'h1);
    @(negedge clk);
    check("busy_low_after_done", (busy_o == 1'b0) && (done_o == 1'b0), {30'h0, busy_o, done_o}, 32'h0);
    repeat (5) @(negedge clk);
    check("bytes_drained", exp_bytes.size() == 0, exp_bytes.size(), 32'h0);
    check("reads_drained", exp_reads.size() == 0, exp_reads.size(), 32'h0);
    check("done_pulse_count", done_cnt - d0 == 1, done_cnt - d0, 32'h1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int d0, b0;
    mem_addr[0] = 32'h1000_0000; mem_addr[1] = 32'h0000_0000;
    mem_addr[2] = 32'h0000_0004; mem_addr[3] = 32'hFFFF_FFFC;
    mem_data[0] = 32'h4433_2211; mem_data[1] = 32'hFFFF_FFFF;
    mem_data[2] = 32'h0000_0001; mem_data[3] = 32'h0102_0304;
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; word_cnt_i = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_o == 1'b1, {31'h0, tx_o}, 32'h1);
    check("rst_req", req_o == 1'b0, {31'h0, req_o}, 32'h0);
    check("rst_addr", addr_o == 32'h0, addr_o, 32'h0);
    check("rst_busy_done", (busy_o == 1'b0) && (done_o == 1'b0), {30'h0, busy_o, done_o}, 32'h0);
    // start_i coincident with rst must be dropped.
    start_i = 1'b1; base_addr_i = 32'h1000_0000; word_cnt_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("start_during_rst", busy_o == 1'b0, {31'h0, busy_o}, 32'h0);

    // One word.
    push8(8'hA5); push8(8'h11); push8(8'h22); push8(8'h33); push8(8'h44); push8(8'hAA);
    exp_reads.push_back(32'h1000_0000);
    d0 = done_cnt;
    start_frame(32'h1000_0000, 16'd1);
    finish_frame(6, d0);

    // Zero words: header and zero checksum only.
    push8(8'hA5); push8(8'h00);
    d0 = done_cnt;
    start_frame(32'h1000_0000, 16'd0);
    finish_frame(2, d0);

    // Unaligned base is forced to 0; checksum wraps.
    push8(8'hA5); push8(8'hFF); push8(8'hFF); push8(8'hFF); push8(8'hFF);
    push8(8'h01); push8(8'h00); push8(8'h00); push8(8'h00); push8(8'hFD);
    exp_reads.push_back(32'h0000_0000); exp_reads.push_back(32'h0000_0004);
    d0 = done_cnt;
    start_frame(32'h0000_0003, 16'd2);
    finish_frame(10, d0);

    // Address wraps from the top of the space to 0.
    mem_data[1] = 32'h1020_3040;
    push8(8'hA5); push8(8'h04); push8(8'h03); push8(8'h02); push8(8'h01);
    push8(8'h40); push8(8'h30); push8(8'h20); push8(8'h10); push8(8'hAA);
    exp_reads.push_back(32'hFFFF_FFFC); exp_reads.push_back(32'h0000_0000);
    d0 = done_cnt;
    start_frame(32'hFFFF_FFFC, 16'd2);
    finish_frame(10, d0);

    // start_i re-pulsed mid-frame is ignored.
    push8(8'hA5); push8(8'h11); push8(8'h22); push8(8'h33); push8(8'h44); push8(8'hAA);
    exp_reads.push_back(32'h1000_0000);
    d0 = done_cnt;
    start_frame(32'h1000_0000, 16'd1);
    repeat (100) @(negedge clk);
    base_addr_i = 32'h0000_0000; word_cnt_i = 16'd2; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    finish_frame(6, d0);
    d0 = done_cnt; b0 = byte_cnt;
    repeat (200) @(negedge clk);
    check("no_second_frame", (done_cnt == d0) && (byte_cnt == b0) && (busy_o == 1'b0),
          byte_cnt - b0, 32'h0);

    // Reset during the third data byte, then a clean frame.
    mem_data[0] = 32'h4400_2211;
    push8(8'hA5); push8(8'h11); push8(8'h22);
    exp_reads.push_back(32'h1000_0000);
    b0 = byte_cnt;
    start_frame(32'h1000_0000, 16'd1);
    for (int i = 0; i < 400; i++) begin
      if (byte_cnt - b0 >= 3) break;
      @(negedge clk);
    end
    check("reached_third_data_byte", byte_cnt - b0 == 3, byte_cnt - b0, 32'h3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx_o == 1'b1, {31'h0, tx_o}, 32'h1);
    check("mid_rst_req_busy", (req_o == 1'b0) && (busy_o == 1'b0), {30'h0, req_o, busy_o}, 32'h0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_rst_bytes", exp_bytes.size() == 0, exp_bytes.size(), 32'h0);
    push8(8'hA5); push8(8'h11); push8(8'h22); push8(8'h00); push8(8'h44); push8(8'h77);
    exp_reads.push_back(32'h1000_0000);
    d0 = done_cnt;
    start_frame(32'h1000_0000, 16'd1);
    finish_frame(6, d0);

    check("req_tx_overlap", overlap_cnt == 0, overlap_cnt, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
